// File: rtl/sid_voice_sched_pkg.sv
// Shared types for the SID voice scheduler: schedule states, datapath phases, sync bundle.
// SID_DUAL_EN selects the two-chip (6 voice) configuration.
package sid;

`ifdef SID_DUAL_EN
    localparam int NVOICES = 6;
`else
    localparam int NVOICES = 3;
`endif

    typedef enum logic [2:0] {
        IDLE, ACC, CAPM, EVAL, SYNC, CAPM2, LATCH, DONE
    } sched_state_e;

    typedef logic [2:0] phase_t;
    localparam phase_t PH_PHI2_PHI1 = 3'b001;
    localparam phase_t PH_PHI1      = 3'b010;
    localparam phase_t PH_PHI1_PHI2 = 3'b100;

    typedef struct packed {
        logic msb;
        logic sync;
    } sync_t;

    // Sync source is the previous voice in the ring of the same chip.
    function automatic int unsigned sync_src(input int unsigned v);
        return (v / 3) * 3 + ((v % 3) + 2) % 3;
    endfunction

endpackage

// File: rtl/sid_voice_sched.sv
// Sequences the shared waveform datapath over all voices once per SID tick and
// resolves the sync ring with MSB capture / eval passes. SID_DUAL_EN: 6 voices.
module sid_voice_sched
    import sid::*;
#(
    parameter int SLOT_BITS = 3
) (
    input  logic                 clk,
    input  logic                 res_n,
    input  logic                 tick,
    input  logic                 ovr_clr,
    input  sync_t                sync_o_dp,
    output phase_t               phase,
    output logic [SLOT_BITS-1:0] voice,
    output sync_t                sync_i_dp,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    sched_state_e         state_q, state_d;
    logic [SLOT_BITS-1:0] vcnt_d, src_d;
    logic [NVOICES-1:0]   msb_q, msb_d, syn_q, syn_d;
    phase_t               phase_d;
    sync_t                sync_d;
    logic                 busy_d, done_d, ovr_d, last, src_msb, src_syn;

    always_comb begin
        state_d = state_q;
        vcnt_d  = voice;
        msb_d   = msb_q;
        syn_d   = syn_q;
        ovr_d   = overrun;
        last    = (voice == SLOT_BITS'(NVOICES - 1));

        if (ovr_clr)
            ovr_d = 1'b0;
        if (tick && state_q != IDLE)
            ovr_d = 1'b1;

        for (int i = 0; i < NVOICES; i++) begin
            if (voice == SLOT_BITS'(i)) begin
                if (state_q == CAPM || state_q == CAPM2)
                    msb_d[i] = sync_o_dp.msb;
                if (state_q == EVAL)
                    syn_d[i] = sync_o_dp.sync;
            end
        end

        case (state_q)
            IDLE: begin
                vcnt_d = '0;
                if (tick)
                    state_d = ACC;
            end
            DONE: begin
                vcnt_d  = '0;
                state_d = IDLE;
            end
            default: begin
                vcnt_d = last ? '0 : voice + 1'b1;
                if (last) begin
                    case (state_q)
                        ACC:     state_d = CAPM;
                        CAPM:    state_d = EVAL;
                        EVAL:    state_d = SYNC;
                        SYNC:    state_d = CAPM2;
                        CAPM2:   state_d = LATCH;
                        default: state_d = DONE;
                    endcase
                end
            end
        endcase

        // Outputs are registered, so they are decoded from next state and
        // forwarded msb/syn (a capture on the last voice feeds voice 0 next).
        src_d   = SLOT_BITS'(sync_src(int'(unsigned'(vcnt_d))));
        src_msb = 1'b0;
        src_syn = 1'b0;
        for (int i = 0; i < NVOICES; i++) begin
            if (src_d == SLOT_BITS'(i)) begin
                src_msb = msb_d[i];
                src_syn = syn_d[i];
            end
        end

        phase_d = '0;
        sync_d  = '0;
        case (state_d)
            ACC: begin
                phase_d = PH_PHI2_PHI1;
                sync_d  = '{msb: src_msb, sync: 1'b0};
            end
            EVAL:  sync_d = '{msb: src_msb, sync: 1'b0};
            SYNC: begin
                phase_d = PH_PHI1;
                sync_d  = '{msb: src_msb, sync: src_syn};
            end
            LATCH: begin
                phase_d = PH_PHI1_PHI2;
                sync_d  = '{msb: src_msb, sync: src_syn};
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= IDLE;
            voice     <= '0;
            msb_q     <= '0;
            syn_q     <= '0;
            phase     <= '0;
            sync_i_dp <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            voice     <= vcnt_d;
            msb_q     <= msb_d;
            syn_q     <= syn_d;
            phase     <= phase_d;
            sync_i_dp <= sync_d;
            busy      <= busy_d;
            done      <= done_d;
            overrun   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_sid_voice_sched.sv
// Scoreboard bench for sid_voice_sched: slot-level reference model pushes expected
// outputs, a negedge monitor pops and compares whenever busy/done is seen.
module tb_sid_voice_sched;
    import sid::*;

`ifdef SID_DUAL_EN
    localparam int N = 6;
`else
    localparam int N = 3;
`endif

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       tick = 1'b0;
    logic       ovr_clr = 1'b0;
    sync_t      sync_o_dp = '0;
    phase_t     phase;
    logic [2:0] voice;
    sync_t      sync_i_dp;
    logic       busy, done, overrun;

    sid_voice_sched #(.SLOT_BITS(3)) dut (
        .clk(clk), .res_n(res_n), .tick(tick), .ovr_clr(ovr_clr),
        .sync_o_dp(sync_o_dp), .phase(phase), .voice(voice),
        .sync_i_dp(sync_i_dp), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        phase_t     ph;
        logic [2:0] v;
        sync_t      si;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b1;
    bit   mmsb[6];
    bit   msyn[6];
    int   src_tbl[6] = '{2, 0, 1, 5, 3, 4};

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (mon_en && res_n && (busy || done)) begin
            if (q.size() == 0) begin
                check("unexpected_output", int'({busy, done}), 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("phase", int'(phase), int'(e.ph));
                check("voice", int'(voice), int'(e.v));
                check("sync_i_dp", int'(sync_i_dp), int'(e.si));
                check("busy", int'(busy), int'(e.busy));
                check("done", int'(done), int'(e.done));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            mmsb[i] = 1'b0;
            msyn[i] = 1'b0;
        end
    endtask

    // mode 0: datapath returns zeros; 1: random; 2: only voice 2 raises msb/sync
    task automatic run_seq(input int mode, input int ovr_slot, input bit clr_too,
                           input bit tick_at_done);
        exp_t e;
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        for (int slot = 0; slot < 6 * N; slot++) begin
            int p, v, s;
            p = slot / N;
            v = slot % N;
            s = src_tbl[v];
            case (mode)
                0:       sync_o_dp = '0;
                1:       sync_o_dp = sync_t'($urandom_range(0, 3));
                default: sync_o_dp = (v == 2) ? sync_t'(2'b11) : sync_t'(2'b00);
            endcase
            tick    = (slot == ovr_slot);
            ovr_clr = clr_too && (slot == ovr_slot);
            e = '{ph: '0, v: 3'(v), si: '0, busy: 1'b1, done: 1'b0};
            case (p)
                0: begin e.ph = PH_PHI2_PHI1; e.si.msb = mmsb[s]; end
                2: e.si.msb = mmsb[s];
                3: begin e.ph = PH_PHI1; e.si = '{msb: mmsb[s], sync: msyn[s]}; end
                5: begin e.ph = PH_PHI1_PHI2; e.si = '{msb: mmsb[s], sync: msyn[s]}; end
                default: ;
            endcase
            q.push_back(e);
            if (p == 1 || p == 4) mmsb[v] = sync_o_dp.msb;
            if (p == 2) msyn[v] = sync_o_dp.sync;
            @(posedge clk); #1;
            tick    = 1'b0;
            ovr_clr = 1'b0;
        end
        q.push_back('{ph: '0, v: 3'd0, si: '0, busy: 1'b0, done: 1'b1});
        sync_o_dp = '0;
        tick = tick_at_done;
        @(posedge clk); #1 tick = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("queue_drained", q.size(), 0);
        q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_phase", int'(phase), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        @(posedge clk); #1 res_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_phase", int'(phase), 0);
            check("idle_busy", int'(busy), 0);
            check("idle_done", int'(done), 0);
        end

        run_seq(0, -1, 1'b0, 1'b0);
        check("no_overrun", int'(overrun), 0);
        run_seq(2, -1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) run_seq(1, -1, 1'b0, 1'b0);

        run_seq(1, 4, 1'b0, 1'b0);
        check("overrun_set", int'(overrun), 1);
        @(posedge clk); #1 ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;
        check("overrun_clr", int'(overrun), 0);

        run_seq(1, 2, 1'b1, 1'b0);
        check("overrun_set_wins", int'(overrun), 1);
        @(posedge clk); #1 ovr_clr = 1'b1;
        @(posedge clk); #1 ovr_clr = 1'b0;

        run_seq(1, -1, 1'b0, 1'b1);
        check("overrun_at_done", int'(overrun), 1);
        check("no_restart_busy", int'(busy), 0);

        // reset while in SYNC: tick sampled, then 9 more edges lands in first SYNC slot
        mon_en = 1'b0;
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        repeat (3 * N) @(posedge clk);
        #3 check("pre_reset_phase", int'(phase), int'(PH_PHI1));
        res_n = 1'b0;
        #1;
        check("async_phase", int'(phase), 0);
        check("async_voice", int'(voice), 0);
        check("async_sync_i", int'(sync_i_dp), 0);
        check("async_busy", int'(busy), 0);
        check("async_done", int'(done), 0);
        check("async_overrun", int'(overrun), 0);
        @(posedge clk); #1 res_n = 1'b1;
        model_reset();
        q.delete();
        mon_en = 1'b1;
        run_seq(1, -1, 1'b0, 1'b0);
        run_seq(1, -1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
